// File: rtl/divisor_secuencial_n.sv
// Sequential restoring divider: one quotient bit per clock, registered results with a done pulse.
// Optional macro DIVISOR_SIGNO_EN selects two's-complement operands and results.
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | one restoring step per cycle, MSB first
// DONE  | results just registered; done high for this cycle
module divisor_secuencial_n #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] residuo,
  output logic             div_cero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef DIVISOR_SIGNO_EN
  assign a_neg = dividendo[WIDTH-1];
  assign b_neg = divisor[WIDTH-1];
  assign a_mag = a_neg ? (~dividendo + 1'b1) : dividendo;
  assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign a_mag = dividendo;
  assign b_mag = divisor;
`endif

  // rem < dvs always holds, so a restored remainder never carries into bit WIDTH
  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    q_bit  = ~diff[WIDTH];
    rem_nx = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], q_bit};
    q_fin  = neg_q ? (~quo_nx + 1'b1) : quo_nx;
    r_fin  = neg_r ? (~rem_nx + 1'b1) : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == '0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cociente <= '0;
      residuo  <= '0;
      div_cero <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            dvd   <= a_mag;
            dvs   <= b_mag;
            rem   <= '0;
            quo   <= '0;
            cnt   <= CW'(WIDTH - 1);
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (divisor == '0) begin
              cociente <= '1;
              residuo  <= dividendo;
              div_cero <= 1'b1;
              done     <= 1'b1;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            cociente <= q_fin;
            residuo  <= r_fin;
            div_cero <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial_n.sv
// Scoreboard bench for divisor_secuencial_n at WIDTH=4; expectations come from a behavioural
// model (unsigned, or signed when DIVISOR_SIGNO_EN is defined).
module tb_divisor_secuencial_n;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividendo;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] cociente;
  logic [W-1:0] residuo;
  logic         div_cero;

  divisor_secuencial_n #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividendo(dividendo), .divisor(divisor),
    .busy(busy), .done(done), .cociente(cociente), .residuo(residuo), .div_cero(div_cero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  exp_t mon_e;
  logic [W-1:0] rc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa;
    int sd;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
`ifdef DIVISOR_SIGNO_EN
      sa = int'($signed(a));
      sd = int'($signed(b));
`else
      sa = int'({28'd0, a});
      sd = int'({28'd0, b});
`endif
      e.q  = W'(sa / sd);
      e.r  = W'(sa % sd);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("cociente", {28'd0, cociente}, {28'd0, mon_e.q});
        chk("residuo", {28'd0, residuo}, {28'd0, mon_e.r});
        chk("div_cero", {31'd0, div_cero}, {31'd0, mon_e.dz});
        if (mon_e.b != '0) begin
          rc = W'(cociente * mon_e.b + residuo);
          chk("reconstruct", {28'd0, rc}, {28'd0, mon_e.a});
`ifndef DIVISOR_SIGNO_EN
          chk("rem_lt_div", {31'd0, (residuo < mon_e.b)}, 32'd1);
`endif
        end
      end
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    @(posedge clk);
    #1;
    start = 1'b1;
    dividendo = a;
    divisor = b;
    if (push) sbq.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 40 * n) begin
      @(negedge clk);
      cyc++;
      if (done) got++;
    end
    chk("done_count", got, n);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividendo = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cociente", {28'd0, cociente}, 32'd0);
    chk("rst_residuo", {28'd0, residuo}, 32'd0);
    chk("rst_div_cero", {31'd0, div_cero}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 13/3: busy t+1..t+5, done only at t+5
    launch(4'd13, 4'd3, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("busy_t%0d", k), {31'd0, busy}, (k <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("done_t%0d", k), {31'd0, done}, (k == 5) ? 32'd1 : 32'd0);
    end
`ifndef DIVISOR_SIGNO_EN
    chk("q_13_3", {28'd0, cociente}, 32'd4);
    chk("r_13_3", {28'd0, residuo}, 32'd1);
`endif

    // divide by zero, done one cycle after accept, then a normal op clears div_cero
    launch(4'd7, 4'd0, 1'b1);
    @(negedge clk);
    chk("dz_done_t1", {31'd0, done}, 32'd1);
    launch(4'd9, 4'd9, 1'b1);
    wait_results(1);
    chk("dz_cleared", {31'd0, div_cero}, 32'd0);

    // start while busy is ignored
    launch(4'd15, 4'd4, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    dividendo = 4'd2;
    divisor = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_results(1);
    repeat (8) @(negedge clk);

    // reset mid-operation drops the result
    launch(4'd12, 4'd5, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_cociente", {28'd0, cociente}, 32'd0);
    chk("midrst_residuo", {28'd0, residuo}, 32'd0);
    repeat (8) @(negedge clk);
    launch(4'd12, 4'd5, 1'b1);
    wait_results(1);

    // start held high runs back-to-back operations
    @(posedge clk);
    #1;
    start = 1'b1;
    dividendo = 4'd6;
    divisor = 4'd2;
    sbq.push_back(model(4'd6, 4'd2));
    sbq.push_back(model(4'd6, 4'd2));
    wait_results(2);
    start = 1'b0;
    repeat (3) @(negedge clk);

`ifdef DIVISOR_SIGNO_EN
    launch(4'h9, 4'd2, 1'b1);
    wait_results(1);
    chk("s_q_m7_2", {28'd0, cociente}, 32'hD);
    chk("s_r_m7_2", {28'd0, residuo}, 32'hF);
    launch(4'h8, 4'hF, 1'b1);
    wait_results(1);
    chk("s_q_m8_m1", {28'd0, cociente}, 32'h8);
    chk("s_r_m8_m1", {28'd0, residuo}, 32'h0);
    launch(4'd7, 4'hD, 1'b1);
    wait_results(1);
    chk("s_q_7_m3", {28'd0, cociente}, 32'hE);
    chk("s_r_7_m3", {28'd0, residuo}, 32'h1);
`endif

    // all 256 operand pairs in a scrambled order
    for (int i = 0; i < 256; i++) begin
      logic [7:0] idx;
      idx = 8'((i * 37 + 11) & 255);
      launch(idx[7:4], idx[3:0], 1'b1);
      wait_results(1);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
